fdiv_fsqrt_wb_collector: RTL and testbench
==========================================

Name: fdiv_fsqrt_wb_collector

Overview:
- Consumer end of the iterative fdiv/fsqrt unit's output handshake (v_o / yumi_i, result, fflags, rd).
- Accepts completed results into a small FIFO, presents them to the FP register-file writeback arbiter, and accrues sticky fflags at commit for the fcsr.
- Sits in the vanilla core FPU between the divider and the FP writeback mux.

Parameters:
- exp_width_p, 8, exponent width of recoded float
- sig_width_p, 24, significand width; recoded data width is exp_width_p+sig_width_p+1
- reg_addr_width_p, reg_addr_width_gp, destination register index width
- els_p, 2, FIFO depth; legal values are 1 to 8

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- v_i  in  1  divider result valid
- rd_i  in  reg_addr_width_p  destination register of result
- result_i  in  exp_width_p+sig_width_p+1  recoded result
- fflags_i  in  5  exception flags {NV,DZ,OF,UF,NX}
- fsqrt_i  in  1  result came from a sqrt op
- yumi_o  out  1  result consumed; drives divider yumi_i
- wb_v_o  out  1  writeback request valid
- wb_rd_o  out  reg_addr_width_p  writeback register
- wb_data_o  out  exp_width_p+sig_width_p+1  writeback data
- wb_yumi_i  in  1  arbiter commits head entry this cycle
- fflags_o  out  5  accrued sticky flags
- fflags_clear_i  in  1  clear accrued flags (fcsr write)
- fsqrt_cnt_o  out  16  committed sqrt ops, saturating
- fdiv_cnt_o  out  16  committed div ops, saturating

Behaviour:
- Reset (clk_i edge with reset_n_i=0): FIFO empty, pointers 0, fflags_o=0, both counters 0, yumi_o=0, wb_v_o=0. Reset mid-operation discards all buffered entries.
- yumi_o = v_i & ~full. It is combinational in v_i and never asserts without v_i.
- Enqueue on yumi_o: the entry holds {rd_i, result_i, fflags_i, fsqrt_i}.
- wb_v_o = ~empty. wb_rd_o and wb_data_o show the head entry; they are don't-care when empty.
- wb_yumi_i is legal only when wb_v_o=1. A dequeue occurs on wb_yumi_i.
- A simultaneous enqueue and dequeue leaves the count unchanged.
- When full, yumi_o=0 even if wb_yumi_i=1 in the same cycle. There is no full-pass-through.
- Pointers wrap modulo els_p. Full/empty comes from an occupancy counter of width clog2(els_p+1).
- Latency without bypass: a result accepted in cycle N gives wb_v_o=1 in cycle N+1.
- Flag accrual happens at commit only:
  - fflags_o_next = (fflags_clear_i ? 0 : fflags_o) | (wb_yumi_i ? head.fflags : 0).
  - A clear in the same cycle as a commit leaves only the committed flags.
- Counters:
  - On wb_yumi_i, fsqrt_cnt_o or fdiv_cnt_o increments according to head.fsqrt.
  - Counters saturate at 16'hFFFF and are not cleared by fflags_clear_i.

Optional Feature:
- Macro: FDIV_FSQRT_WB_BYPASS_EN.
- Defined: when the FIFO is empty and v_i=1:
  - wb_v_o=1 and wb_rd_o/wb_data_o come straight from the inputs.
  - If wb_yumi_i=1, the result is consumed without an enqueue; yumi_o=1, and flags and counters update from the inputs.
  - Otherwise it is enqueued as normal.
  - This gives zero-cycle latency.
- Undefined: no input-to-wb_* combinational path; minimum latency is 1 cycle.

Decomposition:
- bsg_vanilla_pkg gets the typedef fdiv_wb_entry_s {rd, data, fflags, fsqrt} and the fflags bit-index constants.
- Sub-module fdiv_fsqrt_wb_fifo holds the storage, pointers and occupancy counter.
- The top holds the handshake glue, flag accrual, counters and bypass mux.

Test Plan:
- Single result: v_i=1, rd_i=3, result_i=33'h080000000 (1.0), fflags_i=0, fsqrt_i=1. Required: yumi_o=1 same cycle; wb_v_o=1, wb_rd_o=3 next cycle; after wb_yumi_i, fsqrt_cnt_o=1 and FIFO empty.
- Backpressure, els_p=2, wb_yumi_i held 0: three back-to-back results rd=1,2,3. Required: yumi_o=1,1,0; rd=3 is held until the first commit; then commits in order 1,2,3.
- Flags: commit entries with fflags 5'b00001 then 5'b01000. Required: fflags_o=5'b01001. Then a clear in the same cycle as a commit of 5'b10000 gives fflags_o=5'b10000.
- Simultaneous enqueue/dequeue at occupancy 1 for 10 cycles. Required: occupancy stays 1 and order is preserved.
- Reset with 2 entries buffered (reset_n_i=0 for one edge). Required: wb_v_o=0, fflags_o=0, counters 0 next cycle.
- Bypass build: empty FIFO, v_i=1 with wb_yumi_i=1 in the same cycle. Required: wb_v_o=1 combinationally, fdiv_cnt_o increments, FIFO stays empty.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core FPU types: the fdiv/fsqrt writeback entry, fflags bit
// positions and a saturating counter helper. No build macros.
package bsg_vanilla_pkg;

  localparam int reg_addr_width_gp = 5;
  localparam int fdiv_exp_width_gp = 8;
  localparam int fdiv_sig_width_gp = 24;
  localparam int fdiv_data_width_gp = fdiv_exp_width_gp + fdiv_sig_width_gp + 1;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
  localparam int fflags_nv_gp = 4;
  localparam int fflags_dz_gp = 3;
  localparam int fflags_of_gp = 2;
  localparam int fflags_uf_gp = 1;
  localparam int fflags_nx_gp = 0;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0]  rd;
    logic [fdiv_data_width_gp-1:0] data;
    logic [4:0]                    fflags;
    logic                          fsqrt;
  } fdiv_wb_entry_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/fdiv_fsqrt_wb_collector_if.sv
// Enqueue/dequeue bundle between the collector glue (master) and its result
// FIFO (slave). No build macros.
interface fdiv_fsqrt_wb_collector_if #(
  parameter int width_p = 1
);
  // enq_v is only raised when full=0; deq_v is only raised when empty=0.
  // An entry moves on the clock edge where the corresponding strobe is high.
  logic               enq_v;
  logic [width_p-1:0] enq_data;
  logic               full;
  logic               deq_v;
  logic [width_p-1:0] deq_data;
  logic               empty;

  modport master (
    output enq_v, enq_data, deq_v,
    input  full, empty, deq_data
  );

  modport slave (
    input  enq_v, enq_data, deq_v,
    output full, empty, deq_data
  );
endinterface

// File: rtl/fdiv_fsqrt_wb_fifo.sv
// Circular result buffer for the fdiv/fsqrt writeback collector; full/empty
// come from an occupancy counter. No build macros.
module fdiv_fsqrt_wb_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  fdiv_fsqrt_wb_collector_if.slave    fifo_if
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign fifo_if.full     = (count_q == full_cnt_lp);
  assign fifo_if.empty    = (count_q == '0);
  assign fifo_if.deq_data = mem_q[rd_ptr_q];

  assign enq = fifo_if.enq_v & ~fifo_if.full;
  assign deq = fifo_if.deq_v & ~fifo_if.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by the occupancy counter, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= fifo_if.enq_data;
  end

endmodule

// File: rtl/fdiv_fsqrt_wb_collector.sv
// Collects fdiv/fsqrt results, presents them to the FP writeback arbiter and
// accrues sticky fflags plus per-op commit counters. Build macro
// FDIV_FSQRT_WB_BYPASS_EN adds a zero-latency path when the FIFO is empty.
module fdiv_fsqrt_wb_collector
  import bsg_vanilla_pkg::*;
#(
  parameter int exp_width_p      = 8,
  parameter int sig_width_p      = 24,
  parameter int reg_addr_width_p = reg_addr_width_gp,
  parameter int els_p            = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  input  logic [reg_addr_width_p-1:0]          rd_i,
  input  logic [exp_width_p+sig_width_p:0]     result_i,
  input  logic [4:0]                           fflags_i,
  input  logic                                 fsqrt_i,
  output logic                                 yumi_o,
  output logic                                 wb_v_o,
  output logic [reg_addr_width_p-1:0]          wb_rd_o,
  output logic [exp_width_p+sig_width_p:0]     wb_data_o,
  input  logic                                 wb_yumi_i,
  output logic [4:0]                           fflags_o,
  input  logic                                 fflags_clear_i,
  output logic [15:0]                          fsqrt_cnt_o,
  output logic [15:0]                          fdiv_cnt_o
);

  localparam int data_width_lp = exp_width_p + sig_width_p + 1;

  typedef struct packed {
    logic [reg_addr_width_p-1:0] rd;
    logic [data_width_lp-1:0]    data;
    logic [4:0]                  fflags;
    logic                        fsqrt;
  } entry_t;

  localparam int entry_width_lp = $bits(entry_t);

  fdiv_fsqrt_wb_collector_if #(.width_p(entry_width_lp)) fifo_if ();

  fdiv_fsqrt_wb_fifo #(
    .width_p (entry_width_lp),
    .els_p   (els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .fifo_if   (fifo_if)
  );

  entry_t      in_entry, head_entry, commit_entry;
  logic        wb_v, commit;
  logic [4:0]  fflags_q, fflags_d;
  logic [15:0] fsqrt_cnt_q, fsqrt_cnt_d;
  logic [15:0] fdiv_cnt_q, fdiv_cnt_d;

  assign in_entry   = '{rd: rd_i, data: result_i, fflags: fflags_i, fsqrt: fsqrt_i};
  assign head_entry = entry_t'(fifo_if.deq_data);

  // No pass-through when full: a same-cycle commit does not free a slot early.
  assign yumi_o           = v_i & ~fifo_if.full;
  assign fifo_if.enq_data = in_entry;
  assign fifo_if.deq_v    = wb_yumi_i & ~fifo_if.empty;

`ifdef FDIV_FSQRT_WB_BYPASS_EN
  logic bypass;
  assign bypass        = fifo_if.empty & v_i;
  assign commit_entry  = bypass ? in_entry : head_entry;
  assign wb_v          = ~fifo_if.empty | v_i;
  assign fifo_if.enq_v = yumi_o & ~(bypass & wb_yumi_i);
`else
  assign commit_entry  = head_entry;
  assign wb_v          = ~fifo_if.empty;
  assign fifo_if.enq_v = yumi_o;
`endif

  assign commit    = wb_yumi_i & wb_v;
  assign wb_v_o    = wb_v;
  assign wb_rd_o   = commit_entry.rd;
  assign wb_data_o = commit_entry.data;

  always_comb begin
    fflags_d    = (fflags_clear_i ? 5'b0 : fflags_q) | (commit ? commit_entry.fflags : 5'b0);
    fsqrt_cnt_d = fsqrt_cnt_q;
    fdiv_cnt_d  = fdiv_cnt_q;
    if (commit) begin
      if (commit_entry.fsqrt) fsqrt_cnt_d = sat_inc16(fsqrt_cnt_q);
      else                    fdiv_cnt_d  = sat_inc16(fdiv_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fflags_q    <= '0;
      fsqrt_cnt_q <= '0;
      fdiv_cnt_q  <= '0;
    end else begin
      fflags_q    <= fflags_d;
      fsqrt_cnt_q <= fsqrt_cnt_d;
      fdiv_cnt_q  <= fdiv_cnt_d;
    end
  end

  assign fflags_o    = fflags_q;
  assign fsqrt_cnt_o = fsqrt_cnt_q;
  assign fdiv_cnt_o  = fdiv_cnt_q;

endmodule

// File: tb/tb_fdiv_fsqrt_wb_collector.sv
// Directed bench for fdiv_fsqrt_wb_collector (default build; the bypass case
// runs only when FDIV_FSQRT_WB_BYPASS_EN is defined).
`timescale 1ns/1ps
module tb_fdiv_fsqrt_wb_collector;
  import bsg_vanilla_pkg::*;

  localparam int rw_lp = 5;
  localparam int dw_lp = 33;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n_i;
  always #5 clk = ~clk;

  logic              v_i, fsqrt_i, yumi_o, wb_v_o, wb_yumi_i, fflags_clear_i;
  logic [rw_lp-1:0]  rd_i, wb_rd_o;
  logic [dw_lp-1:0]  result_i, wb_data_o;
  logic [4:0]        fflags_i, fflags_o;
  logic [15:0]       fsqrt_cnt_o, fdiv_cnt_o;

  fdiv_fsqrt_wb_collector #(
    .exp_width_p(8), .sig_width_p(24), .reg_addr_width_p(rw_lp), .els_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .v_i(v_i), .rd_i(rd_i), .result_i(result_i), .fflags_i(fflags_i), .fsqrt_i(fsqrt_i),
    .yumi_o(yumi_o),
    .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_yumi_i(wb_yumi_i),
    .fflags_o(fflags_o), .fflags_clear_i(fflags_clear_i),
    .fsqrt_cnt_o(fsqrt_cnt_o), .fdiv_cnt_o(fdiv_cnt_o)
  );

  // Writeback-side view bundled as {rd, data}.
  fdiv_fsqrt_wb_collector_if #(.width_p(rw_lp + dw_lp)) wb_mon ();
  assign wb_mon.enq_v    = yumi_o;
  assign wb_mon.enq_data = {rd_i, result_i};
  assign wb_mon.full     = v_i & ~yumi_o;
  assign wb_mon.deq_v    = wb_yumi_i & wb_v_o;
  assign wb_mon.deq_data = {wb_rd_o, wb_data_o};
  assign wb_mon.empty    = ~wb_v_o;

  // scoreboard
  logic [rw_lp+dw_lp-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_res(input logic [rw_lp-1:0] rd, input logic [dw_lp-1:0] data,
                           input logic [4:0] ff, input logic sq);
    v_i = 1'b1; rd_i = rd; result_i = data; fflags_i = ff; fsqrt_i = sq;
  endtask

  task automatic drive_idle();
    v_i = 1'b0; rd_i = '0; result_i = '0; fflags_i = '0; fsqrt_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  fdiv_wb_entry_s e;

  initial begin
    reset_n_i = 1'b0; wb_yumi_i = 1'b0; fflags_clear_i = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk); settle();
    check_eq("rst_yumi", yumi_o, 0);
    check_eq("rst_wb_v", wb_v_o, 0);
    check_eq("rst_fflags", fflags_o, 0);
    check_eq("rst_fsqrt_cnt", fsqrt_cnt_o, 0);
    check_eq("rst_fdiv_cnt", fdiv_cnt_o, 0);
    reset_n_i = 1'b1;
    next_cycle();

    // single sqrt result, 1-cycle latency
    drive_res(5'd3, 33'h080000000, 5'b0, 1'b1); settle();
    check_eq("single_yumi", yumi_o, 1);
`ifndef FDIV_FSQRT_WB_BYPASS_EN
    check_eq("single_no_bypass", wb_v_o, 0);
`endif
    next_cycle();
    drive_idle(); settle();
    check_eq("single_wb_v", wb_v_o, 1);
    check_eq("single_wb_rd", wb_rd_o, 3);
    check_eq("single_wb_data", wb_data_o, 33'h080000000);
    wb_yumi_i = 1'b1; settle();
    next_cycle();
    wb_yumi_i = 1'b0; settle();
    check_eq("single_fsqrt_cnt", fsqrt_cnt_o, 1);
    check_eq("single_fdiv_cnt", fdiv_cnt_o, 0);
    check_eq("single_empty", wb_v_o, 0);

    // backpressure with 2 slots
    drive_res(5'd1, 33'h1, 5'b0, 1'b0); settle();
    check_eq("bp_yumi1", yumi_o, 1);
    next_cycle();
    drive_res(5'd2, 33'h2, 5'b0, 1'b0); settle();
    check_eq("bp_yumi2", yumi_o, 1);
    next_cycle();
    drive_res(5'd3, 33'h3, 5'b0, 1'b0); settle();
    check_eq("bp_yumi3_full", yumi_o, 0);
    check_eq("bp_head1", wb_rd_o, 1);
    wb_yumi_i = 1'b1; settle();
    check_eq("bp_no_passthru", yumi_o, 0);
    next_cycle();
    settle();
    check_eq("bp_yumi3_accept", yumi_o, 1);
    check_eq("bp_head2", wb_rd_o, 2);
    next_cycle();
    drive_idle(); settle();
    check_eq("bp_head3", wb_rd_o, 3);
    check_eq("bp_head3_data", wb_data_o, 33'h3);
    next_cycle();
    wb_yumi_i = 1'b0; settle();
    check_eq("bp_empty", wb_v_o, 0);
    check_eq("bp_fdiv_cnt", fdiv_cnt_o, 3);

    // flag accrual at commit
    drive_res(5'd4, 33'h4, 5'b00001, 1'b0); settle();
    next_cycle();
    drive_res(5'd5, 33'h5, 5'b01000, 1'b0); settle();
    check_eq("flags_not_at_enq", fflags_o, 5'b00000);
    next_cycle();
    drive_idle(); wb_yumi_i = 1'b1; settle();
    check_eq("flags_head4", wb_rd_o, 4);
    next_cycle();
    settle();
    check_eq("flags_head5", wb_rd_o, 5);
    check_eq("flags_after_first", fflags_o, 5'b00001);
    next_cycle();
    wb_yumi_i = 1'b0; settle();
    check_eq("flags_accrued", fflags_o, 5'b01001);
    drive_res(5'd6, 33'h6, 5'b10000, 1'b0); settle();
    next_cycle();
    drive_idle(); wb_yumi_i = 1'b1; fflags_clear_i = 1'b1; settle();
    next_cycle();
    wb_yumi_i = 1'b0; fflags_clear_i = 1'b0; settle();
    check_eq("flags_clear_commit", fflags_o, 5'b10000);
    check_eq("flags_fdiv_cnt", fdiv_cnt_o, 6);
    fflags_clear_i = 1'b1; settle();
    next_cycle();
    fflags_clear_i = 1'b0; settle();
    check_eq("flags_clear_only", fflags_o, 5'b00000);
    check_eq("flags_clear_keeps_cnt", fdiv_cnt_o, 6);

    // streaming at occupancy 1
    e.rd = 5'd7; e.data = 33'($urandom_range(32'h7FFF_FFFF, 0)); e.fflags = 5'b0; e.fsqrt = 1'b0;
    drive_res(e.rd, e.data, e.fflags, e.fsqrt);
    exp_q.push_back({e.rd, e.data});
    settle();
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      e.rd = 5'(8 + i); e.data = 33'($urandom_range(32'h7FFF_FFFF, 0)); e.fsqrt = i[0];
      drive_res(e.rd, e.data, 5'b0, e.fsqrt);
      exp_q.push_back({e.rd, e.data});
      wb_yumi_i = 1'b1; settle();
      check_eq("stream_yumi", yumi_o, 1);
      check_eq("stream_wb_v", wb_v_o, 1);
      check_eq("stream_head", wb_mon.deq_data, exp_q.pop_front());
      next_cycle();
    end
    drive_idle(); settle();
    check_eq("stream_last", wb_mon.deq_data, exp_q.pop_front());
    next_cycle();
    wb_yumi_i = 1'b0; settle();
    check_eq("stream_empty", wb_v_o, 0);
    check_eq("stream_fsqrt_cnt", fsqrt_cnt_o, 6);
    check_eq("stream_fdiv_cnt", fdiv_cnt_o, 12);

    // reset with two entries buffered
    drive_res(5'd20, 33'h14, 5'b00010, 1'b0); settle();
    next_cycle();
    drive_res(5'd21, 33'h15, 5'b00100, 1'b1); settle();
    next_cycle();
    drive_idle(); settle();
    check_eq("prerst_full", wb_v_o, 1);
    check_eq("prerst_flags", fflags_o, 5'b00000);
    reset_n_i = 1'b0; settle();
    next_cycle();
    reset_n_i = 1'b1; settle();
    check_eq("midrst_wb_v", wb_v_o, 0);
    check_eq("midrst_fflags", fflags_o, 0);
    check_eq("midrst_fsqrt_cnt", fsqrt_cnt_o, 0);
    check_eq("midrst_fdiv_cnt", fdiv_cnt_o, 0);
    drive_res(5'd22, 33'h16, 5'b0, 1'b0); settle();
    check_eq("postrst_yumi", yumi_o, 1);
    next_cycle();
    drive_idle(); settle();
    check_eq("postrst_head", wb_rd_o, 22);
    wb_yumi_i = 1'b1; settle();
    next_cycle();
    wb_yumi_i = 1'b0; settle();
    check_eq("postrst_fdiv_cnt", fdiv_cnt_o, 1);
    check_eq("postrst_empty", wb_v_o, 0);

`ifdef FDIV_FSQRT_WB_BYPASS_EN
    wb_yumi_i = 1'b1;
    drive_res(5'd23, 33'h17, 5'b00100, 1'b0); settle();
    check_eq("byp_wb_v", wb_v_o, 1);
    check_eq("byp_wb_rd", wb_rd_o, 23);
    check_eq("byp_wb_data", wb_data_o, 33'h17);
    check_eq("byp_yumi", yumi_o, 1);
    next_cycle();
    wb_yumi_i = 1'b0; drive_idle(); settle();
    check_eq("byp_fdiv_cnt", fdiv_cnt_o, 2);
    check_eq("byp_fifo_empty", wb_v_o, 0);
    check_eq("byp_fflags", fflags_o, 5'b00100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
